// File: rtl/btn_conditioner.sv
// btn_conditioner: N-channel push-button front end.
// Each channel has a two-flop synchroniser, polarity normalisation and a
// counter-based debouncer. It produces a clean level, one-cycle press and
// release strobes, and a typematic auto-repeat strobe for held buttons.
// Every output is a flop; btn_raw only reaches the outputs through the
// synchroniser.
module btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    // Raw pin level when the button is not pressed.
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam int   RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int   DCW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int   RCW      = $clog2(RPT_MAX) + 1;

    localparam logic [DCW-1:0] DCNT_ZERO  = DCW'(0);
    localparam logic [DCW-1:0] DCNT_ONE   = DCW'(1);
    localparam logic [DCW-1:0] DCNT_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] RCNT_ZERO  = RCW'(0);
    localparam logic [RCW-1:0] RCNT_ONE   = RCW'(1);
    localparam logic [RCW-1:0] RCNT_DLAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RCNT_PLAST = RCW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RPT   = 2'd2
    } rpt_state_t;

    logic [N_BTN-1:0] sync0_r;
    logic [N_BTN-1:0] sync1_r;

    // Two-flop synchroniser; resets to the idle pin level so that leaving
    // reset with released buttons does not look like a transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_r <= {N_BTN{IDLE_LVL}};
            sync1_r <= {N_BTN{IDLE_LVL}};
        end else begin
            sync0_r <= btn_raw;
            sync1_r <= sync0_r;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic           norm_s;
        logic           accept_s;
        logic           press_ev_s;
        logic           release_ev_s;
        logic           level_r;
        logic           press_r;
        logic           release_r;
        logic           repeat_r;
        logic [DCW-1:0] dcnt_r;
        logic [RCW-1:0] rcnt_r;
        rpt_state_t     state_r;

        // 1 = pressed, whatever the pin polarity.
        assign norm_s       = (ACTIVE_LOW != 0) ? ~sync1_r[i] : sync1_r[i];
        // The differing value has persisted long enough; it is accepted at this edge.
        assign accept_s     = (norm_s != level_r) && (dcnt_r == DCNT_LAST);
        assign press_ev_s   = accept_s & norm_s;
        assign release_ev_s = accept_s & ~norm_s;

        // Debounce counter and accepted level, with press/release strobes
        // registered on the same edge as the level update.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dcnt_r    <= DCNT_ZERO;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else if (norm_s == level_r) begin
                dcnt_r    <= DCNT_ZERO;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else if (dcnt_r == DCNT_LAST) begin
                dcnt_r    <= DCNT_ZERO;
                level_r   <= norm_s;
                press_r   <= norm_s;
                release_r <= ~norm_s;
            end else begin
                dcnt_r    <= dcnt_r + DCNT_ONE;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end
        end

        // Typematic repeat FSM. A release beats a coincident repeat, and a
        // dropped repeat_en beats a coincident repeat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r  <= ST_IDLE;
                rcnt_r   <= RCNT_ZERO;
                repeat_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        rcnt_r <= RCNT_ZERO;
                        if (press_ev_s) begin
                            repeat_r <= 1'b1;
                            state_r  <= repeat_en[i] ? ST_DELAY : ST_IDLE;
                        end else begin
                            repeat_r <= 1'b0;
                            state_r  <= ST_IDLE;
                        end
                    end
                    ST_DELAY: begin
                        if (release_ev_s || !repeat_en[i]) begin
                            state_r  <= ST_IDLE;
                            rcnt_r   <= RCNT_ZERO;
                            repeat_r <= 1'b0;
                        end else if (rcnt_r == RCNT_DLAST) begin
                            state_r  <= ST_RPT;
                            rcnt_r   <= RCNT_ZERO;
                            repeat_r <= 1'b1;
                        end else begin
                            state_r  <= ST_DELAY;
                            rcnt_r   <= rcnt_r + RCNT_ONE;
                            repeat_r <= 1'b0;
                        end
                    end
                    ST_RPT: begin
                        if (release_ev_s || !repeat_en[i]) begin
                            state_r  <= ST_IDLE;
                            rcnt_r   <= RCNT_ZERO;
                            repeat_r <= 1'b0;
                        end else if (rcnt_r == RCNT_PLAST) begin
                            state_r  <= ST_RPT;
                            rcnt_r   <= RCNT_ZERO;
                            repeat_r <= 1'b1;
                        end else begin
                            state_r  <= ST_RPT;
                            rcnt_r   <= rcnt_r + RCNT_ONE;
                            repeat_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        rcnt_r   <= RCNT_ZERO;
                        repeat_r <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_level[i]   = level_r;
        assign btn_press[i]   = press_r;
        assign btn_release[i] = release_r;
        assign btn_repeat[i]  = repeat_r;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner: table-driven segments plus hand-written
// repeat/reset/polarity sequences, all checked through a cycle-indexed
// scoreboard of expected outputs.
module tb_btn_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] repeat_en;
    logic [3:0] btn_level, btn_press, btn_release, btn_repeat;

    logic [3:0] raw_ah;
    logic [3:0] ren_ah;
    logic [3:0] lvl_ah, pr_ah, rl_ah, rp_ah;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cyc;
        bit         ah;
        logic [3:0] lv;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] rp;
    } exp_t;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] ren;
        int         len;
        int         ev_k;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] rp;
        logic [3:0] lvl_after;
    } vec_t;

    exp_t       sb[$];
    logic [3:0] lvl_cur;

    btn_conditioner #(
        .N_BTN(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .repeat_en(repeat_en),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat)
    );

    btn_conditioner #(
        .N_BTN(4), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut_ah (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_ah), .repeat_en(ren_ah),
        .btn_level(lvl_ah), .btn_press(pr_ah), .btn_release(rl_ah),
        .btn_repeat(rp_ah)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual lvl/pr/rl/rp=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input int c, input bit ah, input logic [3:0] lv, input logic [3:0] pr,
                        input logic [3:0] rl, input logic [3:0] rp);
        exp_t e;
        e.cyc = c; e.ah = ah; e.lv = lv; e.pr = pr; e.rl = rl; e.rp = rp;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Drive one table segment and queue the expected outputs for each of its cycles.
    task automatic run_seg(input vec_t v);
        int         c;
        logic [3:0] lv;
        c = cyc;
        btn_raw   = v.raw;
        repeat_en = v.ren;
        for (int k = 1; k <= v.len; k++) begin
            lv = (v.ev_k > 0 && k >= v.ev_k) ? v.lvl_after : lvl_cur;
            push(c + k, 1'b0, lv, (k == v.ev_k) ? v.pr : 4'b0000,
                 (k == v.ev_k) ? v.rl : 4'b0000, (k == v.ev_k) ? v.rp : 4'b0000);
        end
        if (v.ev_k > 0) lvl_cur = v.lvl_after;
        repeat (v.len) @(negedge clk);
    endtask

    // Scoreboard: compare every expectation due at this cycle.
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_stale: expectation for cyc=%0d still pending at cyc=%0d", e.cyc, cyc);
                end else begin
                    act = e.ah ? {lvl_ah, pr_ah, rl_ah, rp_ah}
                               : {btn_level, btn_press, btn_release, btn_repeat};
                    chk($sformatf("sb cyc=%0d dut=%0d", cyc, e.ah), act, {e.lv, e.pr, e.rl, e.rp});
                end
            end
        end
    end

    initial begin
        vec_t tbl[11];
        int   c, p, r, q;
        logic [3:0] lv, pr, rl, rp;

        // raw, ren, len, ev_k, press, release, repeat, level after
        tbl[0]  = '{4'b1111, 4'b0000, 20, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000}; // idle after reset
        tbl[1]  = '{4'b1110, 4'b0000, 36, 6, 4'b0001, 4'b0000, 4'b0001, 4'b0001}; // clean press, hold 30
        tbl[2]  = '{4'b1111, 4'b0000, 10, 6, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b1101, 4'b0000,  3, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000}; // bounce
        tbl[4]  = '{4'b1111, 4'b0000,  1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b1101, 4'b0000,  2, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b1111, 4'b0000,  8, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b1101, 4'b0000, 10, 6, 4'b0010, 4'b0000, 4'b0010, 4'b0010};
        tbl[8]  = '{4'b1111, 4'b0000, 10, 6, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0110, 4'b0000, 10, 6, 4'b1001, 4'b0000, 4'b1001, 4'b1001}; // simultaneous
        tbl[10] = '{4'b1111, 4'b0000, 10, 6, 4'b0000, 4'b1001, 4'b0000, 4'b0000};

        rst_n     = 1'b0;
        btn_raw   = 4'b1111;
        repeat_en = 4'b0000;
        raw_ah    = 4'b0000;
        ren_ah    = 4'b0000;
        lvl_cur   = 4'b0000;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {btn_level, btn_press, btn_release, btn_repeat}, 16'h0000);
        chk("reset_outputs_ah", {lvl_ah, pr_ah, rl_ah, rp_ah}, 16'h0000);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_seg(tbl[i]);

        // Auto-repeat on channel 2, release coinciding with a due repeat.
        c = cyc; p = c + 6;
        repeat_en = 4'b0100; btn_raw = 4'b1011;
        for (int t = c + 1; t <= p + 32; t++) begin
            lv = (t >= p && t < p + 22) ? 4'b0100 : 4'b0000;
            pr = (t == p) ? 4'b0100 : 4'b0000;
            rl = (t == p + 22) ? 4'b0100 : 4'b0000;
            rp = (t == p || (t >= p + 10 && t < p + 22 && (t - p - 10) % 3 == 0)) ? 4'b0100 : 4'b0000;
            push(t, 1'b0, lv, pr, rl, rp);
        end
        wait_until(p + 16); btn_raw = 4'b1111;
        wait_until(p + 32); repeat_en = 4'b0000;

        // Channel 3: drop repeat_en just before a due repeat, re-assert while held.
        c = cyc; p = c + 6;
        repeat_en = 4'b1000; btn_raw = 4'b0111;
        for (int t = c + 1; t <= p + 40; t++) begin
            lv = (t >= p && t < p + 36) ? 4'b1000 : 4'b0000;
            pr = (t == p) ? 4'b1000 : 4'b0000;
            rl = (t == p + 36) ? 4'b1000 : 4'b0000;
            rp = (t == p || t == p + 10) ? 4'b1000 : 4'b0000;
            push(t, 1'b0, lv, pr, rl, rp);
        end
        wait_until(p + 12); repeat_en = 4'b0000;
        wait_until(p + 20); repeat_en = 4'b1000;
        wait_until(p + 30); btn_raw = 4'b1111;
        wait_until(p + 40); repeat_en = 4'b0000;

        // Reset in the middle of DELAY, button held through reset.
        c = cyc; p = c + 6;
        repeat_en = 4'b0100; btn_raw = 4'b1011;
        for (int t = c + 1; t <= p + 5; t++) begin
            lv = (t >= p) ? 4'b0100 : 4'b0000;
            pr = (t == p) ? 4'b0100 : 4'b0000;
            push(t, 1'b0, lv, pr, 4'b0000, pr);
        end
        wait_until(p + 5);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_delay", {btn_level, btn_press, btn_release, btn_repeat}, 16'h0000);
        for (int t = p + 6; t <= p + 8; t++) push(t, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        wait_until(p + 8);
        rst_n = 1'b1;
        r = cyc; q = r + 6;
        for (int t = r + 1; t <= q + 20; t++) begin
            lv = (t >= q && t < q + 17) ? 4'b0100 : 4'b0000;
            pr = (t == q) ? 4'b0100 : 4'b0000;
            rl = (t == q + 17) ? 4'b0100 : 4'b0000;
            rp = (t == q || t == q + 10 || t == q + 13 || t == q + 16) ? 4'b0100 : 4'b0000;
            push(t, 1'b0, lv, pr, rl, rp);
        end
        wait_until(q + 11); btn_raw = 4'b1111;
        wait_until(q + 20); repeat_en = 4'b0000;

        // Active-high instance: reset with pins low, then press channel 0.
        rst_n  = 1'b0;
        raw_ah = 4'b0000;
        repeat (2) @(negedge clk);
        chk("reset_outputs_ah2", {lvl_ah, pr_ah, rl_ah, rp_ah}, 16'h0000);
        rst_n = 1'b1;
        r = cyc;
        for (int t = r + 1; t <= r + 10; t++) push(t, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        wait_until(r + 10);
        c = cyc; p = c + 6;
        raw_ah = 4'b0001;
        for (int t = c + 1; t <= p + 18; t++) begin
            lv = (t >= p && t < p + 14) ? 4'b0001 : 4'b0000;
            pr = (t == p) ? 4'b0001 : 4'b0000;
            rl = (t == p + 14) ? 4'b0001 : 4'b0000;
            push(t, 1'b1, lv, pr, rl, pr);
        end
        wait_until(p + 8); raw_ah = 4'b0000;
        wait_until(p + 18);

        for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: actual pending=%0d required=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
